i2c_mem_responder: RTL and testbench



---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 54 +++++
 rtl/i2c_mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the two-wire memory responder.
// The I2C_RESP_AUTOINC_EN macro (burst mode) is consumed by i2c_mem_responder.
package i2c_pkg;

  localparam int ADDR_WIDTH_DEF = 7;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    WR_DATA,
    ACK_W,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_resp_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA_OUT into the clk domain and produces registered
// edge, START and STOP pulses three clk after the pin change.
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic SCL,
  input  logic SDA_OUT,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [1:0] sclSync_q;
  logic [1:0] sdaSync_q;
  logic       sclPrev_q;
  logic       sdaPrev_q;
  logic       sclRise_q;
  logic       sclFall_q;
  logic       start_q;
  logic       stop_q;

  // Idle bus is high, so the chain resets high to avoid phantom edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclSync_q <= 2'b11;
      sdaSync_q <= 2'b11;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
      sclRise_q <= 1'b0;
      sclFall_q <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      sclSync_q <= {sclSync_q[0], SCL};
      sdaSync_q <= {sdaSync_q[0], SDA_OUT};
      sclPrev_q <= sclSync_q[1];
      sdaPrev_q <= sdaSync_q[1];
      sclRise_q <= sclSync_q[1] & ~sclPrev_q;
      sclFall_q <= ~sclSync_q[1] & sclPrev_q;
      start_q   <= sclSync_q[1] & sclPrev_q & sdaPrev_q & ~sdaSync_q[1];
      stop_q    <= sclSync_q[1] & sclPrev_q & ~sdaPrev_q & sdaSync_q[1];
    end
  end

  // sdaPrev_q holds the line value that matches the registered pulses.
  assign sda       = sdaPrev_q;
  assign scl_rise  = sclRise_q;
  assign scl_fall  = sclFall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_mem_responder.sv
// Target-side responder bridging the two-wire bus to a 1-cycle-latency memory.
// Define I2C_RESP_AUTOINC_EN for burst mode (address auto-increment).
module i2c_mem_responder
  import i2c_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  SCL,
  input  logic                  SDA_OUT,
  output logic                  sda_tx,
  output logic                  ack_n,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic sclRise, sclFall, startDet, stopDet, sdaSync;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .SCL       (SCL),
    .SDA_OUT   (SDA_OUT),
    .scl_rise  (sclRise),
    .scl_fall  (sclFall),
    .start_det (startDet),
    .stop_det  (stopDet),
    .sda       (sdaSync)
  );

  i2c_resp_state_t       state_q, state_d;
  logic [3:0]            bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] rxShift_q, rxShift_d;
  logic [DATA_WIDTH-1:0] txShift_q, txShift_d;
  logic [DATA_WIDTH-1:0] rxNext;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
  logic                  memWe_q, memWe_d;
  logic                  memRe_q, memRe_d;
  logic                  rdLoad_q, rdLoad_d;
  logic                  done_q, done_d;
  logic                  sdaTx_q, sdaTx_d;
  logic                  ackN_q, ackN_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '1;
      rw_q       <= I2C_WRITE;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memWe_q    <= 1'b0;
      memRe_q    <= 1'b0;
      rdLoad_q   <= 1'b0;
      done_q     <= 1'b0;
      sdaTx_q    <= 1'b1;
      ackN_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      rw_q       <= rw_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWe_q    <= memWe_d;
      memRe_q    <= memRe_d;
      rdLoad_q   <= rdLoad_d;
      done_q     <= done_d;
      sdaTx_q    <= sdaTx_d;
      ackN_q     <= ackN_d;
    end
  end

  // Bits are sampled on SCL rise; line outputs only move on SCL fall.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    txShift_d  = rdLoad_q ? mem_rdata : txShift_q;
    rw_d       = rw_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWe_d    = 1'b0;
    memRe_d    = 1'b0;
    rdLoad_d   = memRe_q;
    done_d     = 1'b0;
    sdaTx_d    = sdaTx_q;
    ackN_d     = ackN_q;
    rxNext     = {rxShift_q[DATA_WIDTH-2:0], sdaSync};

    if (stopDet) begin
      state_d    = IDLE;
      bitCnt_d   = '0;
      sdaTx_d    = 1'b1;
      ackN_d     = 1'b1;
      memAddr_d  = '0;
      memWdata_d = '0;
    end else if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = '0;
      sdaTx_d  = 1'b1;
      ackN_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (sclRise) begin
            rxShift_d = rxNext;
            bitCnt_d  = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              memAddr_d = ADDR_WIDTH'(rxNext[DATA_WIDTH-1:1]);
              rw_d      = rxNext[0];
              memRe_d   = (rxNext[0] == I2C_READ);
            end
          end else if (sclFall && bitCnt_q == 4'd8) begin
            ackN_d  = 1'b0;
            state_d = ACK_A;
          end
        end
        ACK_A: begin
          if (sclFall) begin
            ackN_d   = 1'b1;
            bitCnt_d = '0;
            if (rw_q == I2C_READ) begin
              sdaTx_d   = txShift_q[DATA_WIDTH-1];
              txShift_d = {txShift_q[DATA_WIDTH-2:0], 1'b1};
              state_d   = RD_DATA;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (sclRise) begin
            rxShift_d = rxNext;
            bitCnt_d  = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              memWdata_d = rxNext;
              memWe_d    = 1'b1;
              done_d     = 1'b1;
            end
          end else if (sclFall && bitCnt_q == 4'd8) begin
            ackN_d  = 1'b0;
            state_d = ACK_W;
          end
        end
        ACK_W: begin
          if (sclFall) begin
            ackN_d = 1'b1;
`ifdef I2C_RESP_AUTOINC_EN
            memAddr_d = memAddr_q + ADDR_WIDTH'(1);
            bitCnt_d  = '0;
            state_d   = WR_DATA;
`else
            state_d = WAIT_STOP;
`endif
          end
        end
        RD_DATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              sdaTx_d = 1'b1;
              state_d = RD_ACK;
            end else begin
              sdaTx_d   = txShift_q[DATA_WIDTH-1];
              txShift_d = {txShift_q[DATA_WIDTH-2:0], 1'b1};
            end
          end
        end
        RD_ACK: begin
          if (sclRise) begin
            done_d = 1'b1;
            if (sdaSync) begin
              sdaTx_d = 1'b1;
              state_d = WAIT_STOP;
            end else begin
`ifdef I2C_RESP_AUTOINC_EN
              // Entering at the rise leaves the next fall to present bit 7.
              memAddr_d = memAddr_q + ADDR_WIDTH'(1);
              memRe_d   = 1'b1;
              bitCnt_d  = '0;
              state_d   = RD_DATA;
`else
              state_d = WAIT_STOP;
`endif
            end
          end
        end
        WAIT_STOP: begin
          sdaTx_d = 1'b1;
          ackN_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_tx    = sdaTx_q;
  assign ack_n     = ackN_q;
  assign done      = done_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_we    = memWe_q;
  assign mem_re    = memRe_q;

endmodule

// File: tb/tb_i2c_mem_responder.sv
// Scoreboard bench for i2c_mem_responder: a bit-banged initiator drives the bus
// while a small memory model answers mem_re/mem_we.
module tb_i2c_mem_responder;
  import i2c_pkg::*;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       SCL;
  logic       SDA_OUT;
  logic       sda_tx;
  logic       ack_n;
  logic       done;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;

  int checkCount = 0;
  int errorCount = 0;
  int weCount = 0;
  int reCount = 0;
  int doneCount = 0;

  logic [14:0] wrQ[$];
  logic [7:0]  rdQ[$];

  logic [7:0] memArr [128];
  logic       preloadEn = 1'b0;
  logic [6:0] preloadAddr = '0;
  logic [7:0] preloadData = '0;

  always #5 clk = ~clk;

  i2c_mem_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .SCL       (SCL),
    .SDA_OUT   (SDA_OUT),
    .sda_tx    (sda_tx),
    .ack_n     (ack_n),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  always @(posedge clk) begin
    if (preloadEn) memArr[preloadAddr] <= preloadData;
    else if (mem_we) memArr[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= memArr[mem_addr];
  end

  always @(negedge clk) begin
    logic [14:0] exp;
    if (done) doneCount++;
    if (mem_re) reCount++;
    if (mem_we) begin
      weCount++;
      checkOutput("we_expected", 32'(wrQ.size() != 0), 32'd1);
      if (wrQ.size() != 0) begin
        exp = wrQ.pop_front();
        checkOutput("we_addr", 32'(mem_addr), 32'(exp[14:8]));
        checkOutput("we_data", 32'(mem_wdata), 32'(exp[7:0]));
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    preloadAddr = a;
    preloadData = d;
    preloadEn   = 1'b1;
    waitClk(1);
    preloadEn   = 1'b0;
  endtask

  task automatic clockBit(input logic b, output logic txSeen, output logic ackSeen);
    SDA_OUT = b;
    waitClk(Q);
    txSeen  = sda_tx;
    ackSeen = ack_n;
    SCL = 1'b1;
    waitClk(2 * Q);
    SCL = 1'b0;
    waitClk(Q);
  endtask

  task automatic startCond();
    SDA_OUT = 1'b1;
    waitClk(Q);
    SCL = 1'b1;
    waitClk(Q);
    SDA_OUT = 1'b0;
    waitClk(Q);
    SCL = 1'b0;
    waitClk(Q);
  endtask

  task automatic stopCond();
    SDA_OUT = 1'b0;
    waitClk(Q);
    SCL = 1'b1;
    waitClk(Q);
    SDA_OUT = 1'b1;
    waitClk(2 * Q);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ackN);
    logic t, a;
    for (int i = 7; i >= 0; i--) clockBit(b[i], t, a);
    clockBit(1'b1, t, ackN);
  endtask

  task automatic recvByte(input logic masterAck, output logic [7:0] d, output logic txRel);
    logic t, a;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, t, a);
      d[i] = t;
    end
    clockBit(masterAck, txRel, a);
  endtask

  // Full single-byte write transaction; the expected memory write is queued first.
  task automatic applyStimulus(input string tag, input logic [6:0] a, input logic [7:0] d);
    logic ak;
    wrQ.push_back({a, d});
    startCond();
    sendByte({a, I2C_WRITE}, ak);
    checkOutput({tag, "_addr_ack"}, 32'(ak), 32'd0);
    sendByte(d, ak);
    checkOutput({tag, "_data_ack"}, 32'(ak), 32'd0);
    stopCond();
    waitClk(4);
  endtask

  task automatic readTxn(input string tag, input logic [6:0] a, input logic [7:0] expData);
    logic       ak, rel;
    logic [7:0] d, exp;
    startCond();
    sendByte({a, I2C_READ}, ak);
    checkOutput({tag, "_addr_ack"}, 32'(ak), 32'd0);
    rdQ.push_back(expData);
    recvByte(1'b1, d, rel);
    exp = rdQ.pop_front();
    checkOutput({tag, "_data"}, 32'(d), 32'(exp));
    checkOutput({tag, "_ack_slot_released"}, 32'(rel), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         we0, re0, d0;
    logic       ak, t, a;
    logic [7:0] bits;

    reset_n = 1'b0;
    SCL     = 1'b1;
    SDA_OUT = 1'b1;
    waitClk(3);
    checkOutput("rst_sda_tx", 32'(sda_tx), 32'd1);
    checkOutput("rst_ack_n", 32'(ack_n), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_re", 32'(mem_re), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset_n = 1'b1;
    waitClk(4);

    $display("[TB] write 0xA5 to 0x12");
    we0 = weCount; d0 = doneCount;
    applyStimulus("wr12", 7'h12, 8'hA5);
    checkOutput("wr12_we_count", 32'(weCount - we0), 32'd1);
    checkOutput("wr12_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("wr12_queue_drained", 32'(wrQ.size()), 32'd0);

    $display("[TB] read 0x05 holding 0x3C, master NACK");
    preload(7'h05, 8'h3C);
    re0 = reCount; d0 = doneCount;
    readTxn("rd05", 7'h05, 8'h3C);
    checkOutput("rd05_re_count", 32'(reCount - re0), 32'd1);
    checkOutput("rd05_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("rd05_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
    stopCond();
    waitClk(4);
    checkOutput("rd05_idle", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] burst write at 0x7F");
    we0 = weCount;
    wrQ.push_back({7'h7F, 8'h11});
    startCond();
    sendByte({7'h7F, I2C_WRITE}, ak);
    checkOutput("burst_addr_ack", 32'(ak), 32'd0);
    sendByte(8'h11, ak);
    checkOutput("burst_b0_ack", 32'(ak), 32'd0);
`ifdef I2C_RESP_AUTOINC_EN
    wrQ.push_back({7'h00, 8'h22});
    sendByte(8'h22, ak);
    checkOutput("burst_b1_ack", 32'(ak), 32'd0);
    stopCond();
    waitClk(4);
    checkOutput("burst_we_count", 32'(weCount - we0), 32'd2);
`else
    sendByte(8'h22, ak);
    checkOutput("burst_b1_nack", 32'(ak), 32'd1);
    stopCond();
    waitClk(4);
    checkOutput("burst_we_count", 32'(weCount - we0), 32'd1);
`endif
    checkOutput("burst_queue_drained", 32'(wrQ.size()), 32'd0);

    $display("[TB] repeated START after 4 address bits");
    we0 = weCount; re0 = reCount;
    startCond();
    bits = 8'hA0;
    for (int i = 7; i >= 4; i--) clockBit(bits[i], t, a);
    startCond();
    checkOutput("rs_state_addr", 32'(dut.state_q), 32'(ADDR));
    wrQ.push_back({7'h33, 8'h5A});
    sendByte({7'h33, I2C_WRITE}, ak);
    checkOutput("rs_addr_ack", 32'(ak), 32'd0);
    sendByte(8'h5A, ak);
    checkOutput("rs_data_ack", 32'(ak), 32'd0);
    stopCond();
    waitClk(4);
    checkOutput("rs_we_count", 32'(weCount - we0), 32'd1);
    checkOutput("rs_re_count", 32'(reCount - re0), 32'd0);

    $display("[TB] STOP after 5 write data bits");
    we0 = weCount;
    startCond();
    sendByte({7'h40, I2C_WRITE}, ak);
    checkOutput("stop5_addr_ack", 32'(ak), 32'd0);
    bits = 8'hB0;
    for (int i = 7; i >= 3; i--) clockBit(bits[i], t, a);
    stopCond();
    waitClk(4);
    checkOutput("stop5_we_count", 32'(weCount - we0), 32'd0);
    checkOutput("stop5_sda_tx", 32'(sda_tx), 32'd1);
    checkOutput("stop5_ack_n", 32'(ack_n), 32'd1);
    checkOutput("stop5_done", 32'(done), 32'd0);
    checkOutput("stop5_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("stop5_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("stop5_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] reset asserted mid read byte");
    preload(7'h09, 8'h00);
    startCond();
    sendByte({7'h09, I2C_READ}, ak);
    checkOutput("mrst_addr_ack", 32'(ak), 32'd0);
    clockBit(1'b1, t, a);
    clockBit(1'b1, t, a);
    waitClk(2);
    checkOutput("mrst_tx_before", 32'(sda_tx), 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("mrst_sda_tx", 32'(sda_tx), 32'd1);
    checkOutput("mrst_ack_n", 32'(ack_n), 32'd1);
    SDA_OUT = 1'b1;
    SCL = 1'b1;
    waitClk(4);
    reset_n = 1'b1;
    waitClk(8);
    checkOutput("mrst_state", 32'(dut.state_q), 32'(IDLE));
    we0 = weCount; re0 = reCount;
    applyStimulus("post", 7'h20, 8'h66);
    readTxn("post_rd", 7'h20, 8'h66);
    stopCond();
    waitClk(4);
    checkOutput("post_we_count", 32'(weCount - we0), 32'd1);
    checkOutput("post_re_count", 32'(reCount - re0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
